// File: rtl/dp_pkg.sv
// Shared encodings for the ALU/register-file datapath: opcodes, FSM states and op classification.
package dp_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_PASSA = 4'd0;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd7;
  localparam logic [OP_W-1:0] OP_SHL   = 4'd8;
  localparam logic [OP_W-1:0] OP_SHR   = 4'd9;
  localparam logic [OP_W-1:0] OP_INC   = 4'd10;
  localparam logic [OP_W-1:0] OP_DEC   = 4'd11;
  localparam logic [OP_W-1:0] OP_CLR   = 4'd12;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd13;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  // Ops that hold the port busy until a deferred writeback.
  function automatic logic is_multicycle(input logic [OP_W-1:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/dp_seq_mul.sv
// Shift-add multiplier: one partial product per cycle, low DATA_W bits of the product.
module dp_seq_mul
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done_c,
  output logic [DATA_W-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;

  // The final iteration's sum is offered combinationally so the owner can write it back on that edge.
  always_comb begin
    product_c = acc_q + (b_q[0] ? a_q : '0);
    done_c    = run_q && (cnt_q == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= product_c;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (done_c) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_regfile_dp.sv
// ALU/register-file datapath: register file with AR/PC/DR taps, zero flag, and a
// valid/ready op port that stalls for the sequential multiplier.
module alu_regfile_dp
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned SEL_W      = $clog2(NUM_REGS),
  parameter int unsigned AR_IDX     = 0,
  parameter int unsigned PC_IDX     = 1,
  parameter int unsigned DR_IDX     = 2,
  parameter int unsigned INS_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [OP_W-1:0]       alu_op,
  input  logic [SEL_W-1:0]      a_sel,
  input  logic [SEL_W-1:0]      b_sel,
  input  logic [SEL_W-1:0]      c_sel,
  input  logic                  c_we,
  input  logic                  z_en,
  input  logic [NUM_REGS-1:0]   inc_mask,
  input  logic                  ld_dr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic [DATA_W-1:0]     ram_address,
  output logic [INS_ADDR_W-1:0] ins_address,
  output logic                  z,
  output logic                  busy
);

  logic [DATA_W-1:0] regs      [NUM_REGS];
  logic [DATA_W-1:0] regs_next [NUM_REGS];

  state_t            state;
  logic [SEL_W-1:0]  mul_sel;
  logic              mul_we;
  logic              mul_z;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] alu_res;

  logic              wb_en;
  logic              wb_z;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_data;

  assign accept    = op_valid & op_ready;
  assign mul_start = accept & is_multicycle(alu_op);
  assign a_val     = regs[a_sel];
  assign b_val     = regs[b_sel];

  // Single-cycle ALU; reserved codes and MUL fall through to PASSA.
  always_comb begin
    alu_res = a_val;
    case (alu_op)
      OP_PASSB: alu_res = b_val;
      OP_ADD:   alu_res = a_val + b_val;
      OP_SUB:   alu_res = a_val - b_val;
      OP_AND:   alu_res = a_val & b_val;
      OP_OR:    alu_res = a_val | b_val;
      OP_XOR:   alu_res = a_val ^ b_val;
      OP_NOT:   alu_res = ~a_val;
      OP_SHL:   alu_res = a_val << 1;
      OP_SHR:   alu_res = a_val >> 1;
      OP_INC:   alu_res = a_val + 1'b1;
      OP_DEC:   alu_res = a_val - 1'b1;
      OP_CLR:   alu_res = '0;
      default:  alu_res = a_val;
    endcase
  end

  dp_seq_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (a_val),
    .b         (b_val),
    .done_c    (mul_done),
    .product_c (mul_prod)
  );

  // Writeback source: the finishing multiply, else an accepted single-cycle op.
  always_comb begin
    wb_en   = 1'b0;
    wb_z    = 1'b0;
    wb_sel  = '0;
    wb_data = '0;
    if (state == ST_MUL) begin
      if (mul_done) begin
        wb_en   = mul_we;
        wb_z    = mul_z;
        wb_sel  = mul_sel;
        wb_data = mul_prod;
      end
    end else if (accept && !is_multicycle(alu_op)) begin
      wb_en   = c_we;
      wb_z    = z_en;
      wb_sel  = c_sel;
      wb_data = alu_res;
    end
  end

  // Per-register priority: writeback over ld_dr over increment; losers are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_next[i] = regs[i];
      if (inc_mask[SEL_W'(i)]) regs_next[i] = regs[i] + 1'b1;
      if (ld_dr && (i == DR_IDX)) regs_next[i] = data_in;
      if (wb_en && (wb_sel == SEL_W'(i))) regs_next[i] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else begin
      regs <= regs_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_ready <= 1'b1;
      busy     <= 1'b0;
      z        <= 1'b0;
      mul_sel  <= '0;
      mul_we   <= 1'b0;
      mul_z    <= 1'b0;
    end else begin
      if (wb_z) z <= (wb_data == '0);
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state    <= ST_MUL;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            mul_sel  <= c_sel;
            mul_we   <= c_we;
            mul_z    <= z_en;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state    <= ST_IDLE;
            op_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_out    = regs[DR_IDX];
  assign ram_address = regs[AR_IDX];
  assign ins_address = regs[PC_IDX][INS_ADDR_W-1:0];

endmodule

// File: tb/tb_alu_regfile_dp.sv
// Directed bench for alu_regfile_dp: stimulus queues expected port values per cycle, a negedge monitor checks them.
module tb_alu_regfile_dp;
  import dp_pkg::*;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned INS_W    = 8;

  localparam int F_DOUT  = 0;
  localparam int F_RAM   = 1;
  localparam int F_INS   = 2;
  localparam int F_Z     = 3;
  localparam int F_READY = 4;
  localparam int F_BUSY  = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                op_valid;
  logic                op_ready;
  logic [3:0]          alu_op;
  logic [SEL_W-1:0]    a_sel, b_sel, c_sel;
  logic                c_we, z_en;
  logic [NUM_REGS-1:0] inc_mask;
  logic                ld_dr;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W-1:0]   data_out;
  logic [DATA_W-1:0]   ram_address;
  logic [INS_W-1:0]    ins_address;
  logic                z;
  logic                busy;

  alu_regfile_dp #(
    .DATA_W (DATA_W), .NUM_REGS (NUM_REGS), .AR_IDX (0), .PC_IDX (1),
    .DR_IDX (2), .INS_ADDR_W (INS_W)
  ) dut (
    .clk (clk), .rst (rst), .op_valid (op_valid), .op_ready (op_ready),
    .alu_op (alu_op), .a_sel (a_sel), .b_sel (b_sel), .c_sel (c_sel),
    .c_we (c_we), .z_en (z_en), .inc_mask (inc_mask), .ld_dr (ld_dr),
    .data_in (data_in), .data_out (data_out), .ram_address (ram_address),
    .ins_address (ins_address), .z (z), .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    int          field;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int f);
    case (f)
      F_DOUT:  return data_out;
      F_RAM:   return ram_address;
      F_INS:   return 16'(ins_address);
      F_Z:     return 16'(z);
      F_READY: return 16'(op_ready);
      default: return 16'(busy);
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (actual(sb[i].field) !== sb[i].val) begin
          errors++;
          $display("FAIL %s (cycle %0d): actual=%h required=%h",
                   sb[i].name, cyc, actual(sb[i].field), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_push(input string name, input int f, input logic [15:0] v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.field = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    op_valid = 1'b0; alu_op = OP_PASSA; a_sel = '0; b_sel = '0; c_sel = '0;
    c_we = 1'b0; z_en = 1'b0; inc_mask = '0; ld_dr = 1'b0; data_in = '0;
  endtask

  task automatic set_op(input logic [3:0] op, input int a, input int b, input int c,
                        input logic we, input logic ze);
    op_valid = 1'b1; alu_op = op; a_sel = SEL_W'(a); b_sel = SEL_W'(b);
    c_sel = SEL_W'(c); c_we = we; z_en = ze;
  endtask

  // Load a register through DR, then copy DR into it.
  task automatic load_reg(input int r, input logic [15:0] v);
    idle_in(); ld_dr = 1'b1; data_in = v; tick();
    idle_in(); set_op(OP_PASSA, 2, 0, r, 1'b1, 1'b0); tick();
    idle_in();
  endtask

  typedef struct { logic [3:0] op; logic [15:0] res; string name; } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{OP_PASSB, 16'h0005, "passb"};
    vecs[1]  = '{OP_SUB,   16'h122F, "sub"};
    vecs[2]  = '{OP_AND,   16'h0004, "and"};
    vecs[3]  = '{OP_OR,    16'h1235, "or"};
    vecs[4]  = '{OP_XOR,   16'h1231, "xor"};
    vecs[5]  = '{OP_NOT,   16'hEDCB, "not"};
    vecs[6]  = '{OP_SHL,   16'h2468, "shl"};
    vecs[7]  = '{OP_SHR,   16'h091A, "shr"};
    vecs[8]  = '{OP_INC,   16'h1235, "inc"};
    vecs[9]  = '{OP_DEC,   16'h1233, "dec"};
    vecs[10] = '{OP_CLR,   16'h0000, "clr"};
    vecs[11] = '{4'd14,    16'h1234, "reserved14"};

    rst = 1'b1;
    idle_in();
    tick(); tick();
    exp_push("rst_dout", F_DOUT, 16'h0000);
    exp_push("rst_ram", F_RAM, 16'h0000);
    exp_push("rst_ins", F_INS, 16'h0000);
    exp_push("rst_z", F_Z, 16'h0000);
    exp_push("rst_ready", F_READY, 16'h0001);
    exp_push("rst_busy", F_BUSY, 16'h0000);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_now: actual=%b required=1", op_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_now: actual=%b required=0", busy);
    end
    rst = 1'b0;
    tick();

    // ADD wrapping to zero sets Z.
    load_reg(4, 16'h0003);
    load_reg(5, 16'hFFFD);
    set_op(OP_ADD, 4, 5, 3, 1'b1, 1'b1); tick();
    exp_push("add_z", F_Z, 16'h0001);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL add_z_now: actual=%b required=1", z);
    end
    idle_in(); set_op(OP_PASSA, 3, 0, 2, 1'b1, 1'b0); tick();
    exp_push("add_r3", F_DOUT, 16'h0000);

    // MUL: 16 busy cycles, re-presented op ignored, ready back with result.
    load_reg(4, 16'h0102);
    load_reg(5, 16'h0010);
    set_op(OP_MUL, 4, 5, 6, 1'b1, 1'b0); tick();
    exp_push("mul_ready_lo", F_READY, 16'h0000);
    exp_push("mul_busy_hi", F_BUSY, 16'h0001);
    for (int i = 1; i <= 16; i++) begin
      set_op(OP_CLR, 0, 0, 2, 1'b1, 1'b1); tick();
      exp_push("mul_ready", F_READY, (i < 16) ? 16'h0000 : 16'h0001);
      exp_push("mul_busy", F_BUSY, (i < 16) ? 16'h0001 : 16'h0000);
      exp_push("mul_dr_held", F_DOUT, 16'h0010);
    end
    idle_in(); set_op(OP_PASSA, 6, 0, 2, 1'b1, 1'b0); tick();
    exp_push("mul_result", F_DOUT, 16'h1020);

    // Same-edge write priority on DR.
    load_reg(4, 16'h0050);
    load_reg(5, 16'h0005);
    set_op(OP_ADD, 4, 5, 2, 1'b1, 1'b0);
    ld_dr = 1'b1; data_in = 16'hAAAA; inc_mask = 8'b0000_0100; tick();
    exp_push("prio_wb", F_DOUT, 16'h0055);
    checks++;
    if (data_out !== 16'h0055) begin
      errors++;
      $display("FAIL prio_wb_now: actual=%h required=0055", data_out);
    end
    idle_in(); ld_dr = 1'b1; data_in = 16'h1234; inc_mask = 8'b0000_0100; tick();
    exp_push("prio_ld", F_DOUT, 16'h1234);
    idle_in(); inc_mask = 8'b0000_0100; tick();
    exp_push("inc_dr", F_DOUT, 16'h1235);

    // Z follows z_en without c_we.
    idle_in(); set_op(OP_PASSA, 4, 0, 0, 1'b0, 1'b1); tick();
    exp_push("z_clear", F_Z, 16'h0000);
    load_reg(4, 16'h1234);
    set_op(OP_SUB, 4, 2, 2, 1'b0, 1'b1); tick();
    exp_push("sub_nowe_z", F_Z, 16'h0001);
    exp_push("sub_nowe_dr", F_DOUT, 16'h1234);

    // ALU op table with A=R4=0x1234, B=R5=0x0005.
    for (int i = 0; i < 12; i++) begin
      idle_in(); set_op(vecs[i].op, 4, 5, 2, 1'b1, 1'b1); tick();
      exp_push(vecs[i].name, F_DOUT, vecs[i].res);
      exp_push({vecs[i].name, "_z"}, F_Z, (vecs[i].res == 16'h0) ? 16'h1 : 16'h0);
    end

    // PC increments 260 times; ins_address wraps at 256.
    idle_in();
    for (int n = 1; n <= 260; n++) begin
      inc_mask = 8'b0000_0010; tick();
      if (n == 256) exp_push("pc_wrap", F_INS, 16'h0000);
    end
    exp_push("pc_260", F_INS, 16'h0004);
    exp_push("pc_ram_untouched", F_RAM, 16'h0000);
    checks++;
    if (ins_address !== 8'h04) begin
      errors++;
      $display("FAIL pc_260_now: actual=%h required=04", ins_address);
    end
    checks++;
    if (ram_address !== 16'h0000) begin
      errors++;
      $display("FAIL pc_ram_now: actual=%h required=0000", ram_address);
    end
    idle_in(); set_op(OP_PASSA, 1, 0, 2, 1'b1, 1'b0); tick();
    exp_push("pc_full", F_DOUT, 16'h0104);

    // AR increment wraps 0xFFFF to 0.
    load_reg(0, 16'hFFFF);
    exp_push("ar_max", F_RAM, 16'hFFFF);
    inc_mask = 8'b0000_0001; tick();
    exp_push("ar_wrap", F_RAM, 16'h0000);

    // Reset in the middle of a multiply aborts it.
    load_reg(2, 16'h1234);
    set_op(OP_MUL, 4, 5, 2, 1'b1, 1'b1); tick();
    idle_in();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; tick();
    exp_push("abort_dout", F_DOUT, 16'h0000);
    exp_push("abort_ins", F_INS, 16'h0000);
    exp_push("abort_z", F_Z, 16'h0000);
    exp_push("abort_ready", F_READY, 16'h0001);
    exp_push("abort_busy", F_BUSY, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    exp_push("abort_no_wb", F_DOUT, 16'h0000);
    exp_push("abort_ready_later", F_READY, 16'h0001);

    tick(); tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never observed, required=%h", sb[0].name, sb[0].val);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
